// File: rtl/skidbuf_pkg.sv
// Shared types and constants for the skidbuf elastic stage.
package skidbuf_pkg;

  // Fill level of the stage: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skidstate_t;

  // Width of the occupancy count (0, 1 or 2 entries).
  localparam int unsigned OCC_W = 2;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input skidstate_t s);
    logic [OCC_W-1:0] n;
    n = '0;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/skidbuf_flopenrn.sv
// Enable flop, WIDTH bits, asynchronous active-low reset to zero.
module flopenrn #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, otherwise hold.
  // NOTE: payload registers are reset to zero so out_data is defined after reset; a pure data path could skip this reset to save reset routing.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skidbuf.sv
// Two-entry elastic stage with registered in_ready; drives the load enable
// and data of a downstream enable-flop register.
module skidbuf
  import skidbuf_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_en,
  output logic [OCC_W-1:0] occupancy
);

  skidstate_t       state, state_next;
  logic             in_fire, out_fire;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next state and register load enables; flush overrides every transition
  // and suppresses all loads, so a beat accepted alongside flush is dropped.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_en    = 1'b1;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              state_next = FULL;
              skid_en    = 1'b1;
            end
            2'b01: state_next = EMPTY;
            2'b11: main_en    = 1'b1;
            default: state_next = ONE;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            state_next     = ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // in_ready is computed from the next state and registered, which cuts any
  // combinational path from out_ready back to the producer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_next != FULL);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  flopenrn #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .resetn (resetn),
    .en     (main_en),
    .d      (main_d),
    .q      (main_q)
  );

  flopenrn #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .en     (skid_en),
    .d      (in_data),
    .q      (skid_q)
  );

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign out_en    = out_fire;
  assign occupancy = occ_of(state);

endmodule
